dataflow_rx: RTL and testbench

Serial receiver that pairs with the team's `Dataflow_Tx` transmitter on the same single-wire link. It consumes one line bit per clock, with no oversampling. The frame is a start bit (0), n data bits LSB first, one parity bit, and a stop bit (1). It presents the recovered word with a one-cycle valid strobe plus parity and framing status, and sits at the far end of the link, feeding whatever block consumes received bytes.

---
 rtl/dataflow_rx.sv | 162 ++++++++++++++++
 tb/tb_dataflow_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_rx.sv
`default_nettype none
// ============================================================================
//  Module   : dataflow_rx
//  Purpose  : Single-wire serial receiver, one line bit per clock.
//             Frame = start(0), n data bits LSB first, parity, stop(1).
//             Presents the recovered word with a one-cycle valid strobe
//             plus parity and framing status.
//  Revision : 1.0  initial release
// ============================================================================
module dataflow_rx #(
    parameter int   n                    = 8,
    parameter logic parity_type_even_odd = 1'b0   // 0 = even, 1 = odd
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Rx,
    output logic [n-1:0] Q,
    output logic         valid,
    output logic         parity_error,
    output logic         frame_error,
    output logic         busy
);

    // Bit counter must be at least one bit wide even for a 1-bit word.
    localparam int                  c_cnt_w    = (n > 1) ? $clog2(n) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(n - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DATA      = 3'd1;
    localparam logic [2:0] S_PARITY    = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx_s;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [n-1:0]       r_shift;
    logic               r_par;
    logic [n-1:0]       r_q;
    logic               r_valid;
    logic               r_perr;
    logic               r_ferr;

    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [n-1:0]       w_shift_nxt;
    logic               w_par_nxt;
    logic [n-1:0]       w_q_nxt;
    logic               w_valid_nxt;
    logic               w_perr_nxt;
    logic               w_ferr_nxt;
    logic               w_par_exp;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Parity the transmitter would have sent for the assembled word.
    generate
        if (parity_type_even_odd) begin : g_odd_parity
            assign w_par_exp = ~^r_shift;
        end else begin : g_even_parity
            assign w_par_exp = ^r_shift;
        end
    endgenerate

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Frame sequencing: next state and next datapath/output values.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_q_nxt     = r_q;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        w_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end
            end
            S_DATA: begin
                w_shift_nxt[r_cnt] = w_rx_s;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_PARITY;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_PARITY: begin
                w_par_nxt   = w_rx_s;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Error frames are still delivered; the consumer decides.
                w_q_nxt     = r_shift;
                w_perr_nxt  = (r_par != w_par_exp);
                w_ferr_nxt  = ~w_rx_s;
                w_valid_nxt = 1'b1;
                // A low stop bit may be a break; wait for the line to recover
                // so the held-low level is not mistaken for a start bit.
                w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Q            = r_q;
    assign valid        = r_valid;
    assign parity_error = r_perr;
    assign frame_error  = r_ferr;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dataflow_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dataflow_rx
//  Purpose  : Directed self-checking bench for dataflow_rx (n = 8), with one
//             even-parity and one odd-parity instance on a shared line.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dataflow_rx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx;

    logic [7:0] q_e, q_o;
    logic       valid_e, valid_o;
    logic       perr_e, perr_o;
    logic       ferr_e, ferr_o;
    logic       busy_e, busy_o;

    int         cyc;
    int         n_tests;
    int         n_fail;
    logic       act_e;
    logic       busy_hist [0:8191];
    ev_t        qe [$];
    ev_t        qo [$];

    dataflow_rx #(.n(8), .parity_type_even_odd(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n), .Rx(rx), .Q(q_e), .valid(valid_e),
        .parity_error(perr_e), .frame_error(ferr_e), .busy(busy_e)
    );

    dataflow_rx #(.n(8), .parity_type_even_odd(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n), .Rx(rx), .Q(q_o), .valid(valid_o),
        .parity_error(perr_o), .frame_error(ferr_o), .busy(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after absolute edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Record valid pulses, busy history and any idle-line activity.
    always @(negedge clk) begin
        busy_hist[cyc & 8191] = busy_e;
        if (valid_e) qe.push_back('{d: q_e, pe: perr_e, fe: ferr_e, c: cyc});
        if (valid_o) qo.push_back('{d: q_o, pe: perr_o, fe: ferr_o, c: cyc});
        if (rst_n && (valid_e || busy_e || perr_e || ferr_e)) act_e = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int nb, output int e0);
        e0 = 0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == 0) e0 = cyc + 1;
            rx = bits[i];
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int e0);
        logic [15:0] bits;
        bits = {5'b0, stop, par, d, 1'b0};
        send_bits(bits, 11, e0);
    endtask

    task automatic pop_e(output ev_t ev);
        if (qe.size() > 0) ev = qe.pop_front();
        else ev = '{d: 8'h00, pe: 1'b0, fe: 1'b0, c: -1000};
    endtask

    task automatic pop_o(output ev_t ev);
        if (qo.size() > 0) ev = qo.pop_front();
        else ev = '{d: 8'h00, pe: 1'b0, fe: 1'b0, c: -1000};
    endtask

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e0, e1;
        ev_t ev, ev2;
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        act_e   = 1'b0;
        rx      = 1'b1;
        rst_n   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_Q",     {24'h0, q_e}, 32'h0);
        check("rst_valid", {31'h0, valid_e}, 32'h0);
        check("rst_perr",  {31'h0, perr_e}, 32'h0);
        check("rst_ferr",  {31'h0, ferr_e}, 32'h0);
        check("rst_busy",  {31'h0, busy_e}, 32'h0);
        rst_n = 1'b1;

        // Idle line for 50 clocks
        act_e = 1'b0;
        idle(50);
        check("idle_act",   {31'h0, act_e}, 32'h0);
        check("idle_valid", qe.size(), 0);

        // Even-parity frame 0x55, parity 0
        qe.delete(); qo.delete();
        send_frame(8'h55, 1'b0, 1'b1, e0);
        idle(5);
        check("f55_count", qe.size(), 1);
        pop_e(ev);
        check("f55_Q",    {24'h0, ev.d}, 32'h55);
        check("f55_perr", {31'h0, ev.pe}, 32'h0);
        check("f55_ferr", {31'h0, ev.fe}, 32'h0);
        check("f55_lat",  ev.c - e0, 12);
        check("f55_busy1",  {31'h0, busy_hist[(e0 + 1) & 8191]}, 32'h0);
        check("f55_busy2",  {31'h0, busy_hist[(e0 + 2) & 8191]}, 32'h1);
        check("f55_busy11", {31'h0, busy_hist[(e0 + 11) & 8191]}, 32'h1);
        check("f55_busy12", {31'h0, busy_hist[(e0 + 12) & 8191]}, 32'h0);
        // Same frame seen by the odd-parity receiver has a parity error
        pop_o(ev);
        check("f55_odd_perr", {31'h0, ev.pe}, 32'h1);

        // Bad parity: 0xA3 with parity 1 in even mode
        qe.delete(); qo.delete();
        send_frame(8'hA3, 1'b1, 1'b1, e0);
        idle(5);
        check("fA3_count", qe.size(), 1);
        pop_e(ev);
        check("fA3_Q",    {24'h0, ev.d}, 32'hA3);
        check("fA3_perr", {31'h0, ev.pe}, 32'h1);
        check("fA3_ferr", {31'h0, ev.fe}, 32'h0);
        idle(10);
        check("fA3_hold_Q",    {24'h0, q_e}, 32'hA3);
        check("fA3_hold_perr", {31'h0, perr_e}, 32'h1);

        // Odd mode, back-to-back 0x00 and 0xFF, both parity 1
        qe.delete(); qo.delete();
        send_frame(8'h00, 1'b1, 1'b1, e0);
        send_frame(8'hFF, 1'b1, 1'b1, e1);
        idle(5);
        check("b2b_count", qo.size(), 2);
        pop_o(ev);
        pop_o(ev2);
        check("b2b_Q0",    {24'h0, ev.d}, 32'h00);
        check("b2b_Q1",    {24'h0, ev2.d}, 32'hFF);
        check("b2b_err0",  {30'h0, ev.pe, ev.fe}, 32'h0);
        check("b2b_err1",  {30'h0, ev2.pe, ev2.fe}, 32'h0);
        check("b2b_gap",   ev2.c - ev.c, 11);
        check("b2b_lat",   ev.c - e0, 12);

        // Framing error followed by a 20-clock break, then a good frame
        qe.delete(); qo.delete();
        send_frame(8'h3C, 1'b0, 1'b0, e0);
        repeat (20) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(2);
        send_frame(8'h81, 1'b0, 1'b1, e1);
        idle(5);
        check("brk_count", qe.size(), 2);
        pop_e(ev);
        pop_e(ev2);
        check("brk_Q0",    {24'h0, ev.d}, 32'h3C);
        check("brk_ferr0", {31'h0, ev.fe}, 32'h1);
        check("brk_perr0", {31'h0, ev.pe}, 32'h0);
        check("brk_Q1",    {24'h0, ev2.d}, 32'h81);
        check("brk_ferr1", {31'h0, ev2.fe}, 32'h0);
        check("brk_perr1", {31'h0, ev2.pe}, 32'h0);

        // Reset after data bit 3 of 0x5A, then frame 0x12
        qe.delete(); qo.delete();
        send_bits(16'b0_1010_0, 5, e0);   // start, then bits 0..3 of 0x5A
        @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_Q",     {24'h0, q_e}, 32'h0);
        check("mrst_valid", {31'h0, valid_e}, 32'h0);
        check("mrst_busy",  {31'h0, busy_e}, 32'h0);
        check("mrst_err",   {30'h0, perr_e, ferr_e}, 32'h0);
        rst_n = 1'b1;
        idle(3);
        send_frame(8'h12, 1'b0, 1'b1, e1);
        idle(5);
        check("mrst_count", qe.size(), 1);
        pop_e(ev);
        check("mrst_Q12",  {24'h0, ev.d}, 32'h12);
        check("mrst_err12", {30'h0, ev.pe, ev.fe}, 32'h0);
        check("mrst_lat",  ev.c - e1, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
